vedacao_ctrl: RTL and testbench
===============================

VEDACAO_CTRL -- requirements
Module: vedacao_ctrl

Interface
REQ-001 Parameter SEAL_CYCLES, default 4: number of clock cycles the capper actuator is held on per bottle (range 1..15).
REQ-002 Parameter REFILL, default 15: caps added per refill pulse.
REQ-003 Parameter MAX_STOCK, default 99: saturation ceiling of the cap stock counter.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; reset=0 forces the reset state immediately, independent of clk.
REQ-006 pos_ve  input  1  level; bottle held in sealing position (from main line FSM).
REQ-007 add_rolhas  input  1  refill request; each cycle it is high counts as one refill.
REQ-008 selador  output  1  capper actuator drive.
REQ-009 ve_done  output  1  one-cycle pulse: current bottle sealed.
REQ-010 alarme  output  1  cap stock empty while a bottle is waiting.
REQ-011 estoque  output  7  current cap stock, unsigned, 0..MAX_STOCK.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 States SHALL be IDLE, SEAL, DONE, RELEASE, EMPTY; encoding is free, and state, seal timer and stock counter are registered.
REQ-014 IDLE: pos_ve=1 and estoque>0 -> SEAL with the timer loaded to SEAL_CYCLES-1; pos_ve=1 and estoque=0 -> EMPTY; otherwise remain.
REQ-015 SEAL: selador=1 in every SEAL cycle; the timer decrements each cycle; at timer=0 the FSM goes to DONE and estoque decrements by 1 on that same edge.
REQ-016 SEAL with pos_ve=0 in any cycle (line stopped) -> IDLE on the next edge, no decrement, no ve_done.
REQ-017 DONE: ve_done=1 for exactly one cycle, selador=0, unconditional -> RELEASE.
REQ-018 RELEASE: wait for pos_ve=0, then -> IDLE; this guarantees one seal per bottle even if pos_ve stays high.
REQ-019 EMPTY: alarme=1; pos_ve=0 -> IDLE (alarme drops); estoque>0 (after refill) with pos_ve=1 -> SEAL with the timer loaded.
REQ-020 Latency: pos_ve rising in IDLE with stock available -> selador high the next cycle for SEAL_CYCLES cycles -> ve_done in the cycle after the last selador cycle.
REQ-021 Refill: add_rolhas=1 adds REFILL on the next edge, saturating at MAX_STOCK; it is accepted in every state.
REQ-022 Simultaneous refill and decrement on the same edge: estoque_next = min(estoque+REFILL-1, MAX_STOCK).
REQ-023 Decrement never occurs when estoque=0: SEAL is only entered with estoque>0.
REQ-024 The internal sum SHALL be computed at least 8 bits wide before saturation, so there is no 7-bit wrap.
REQ-025 All outputs are decoded from registered state/counters only; no combinational path from inputs to outputs.

Reset
REQ-026 reset=0: state=IDLE, timer=0, estoque=0, selador=0, ve_done=0, alarme=0, busy=0.
REQ-027 Reset asserted mid-SEAL aborts immediately: selador drops asynchronously, no ve_done, stock is reset to 0.
REQ-028 After reset release, the first active edge evaluates IDLE transitions normally.

Verification
REQ-029 Reset, then one add_rolhas pulse, then pos_ve=1 held -> estoque=15; selador high 4 cycles; ve_done one pulse; estoque=14; no second seal until pos_ve toggles 0->1.
REQ-030 estoque=0 with pos_ve=1 -> alarme=1, selador=0; add_rolhas pulse -> next cycle estoque=15, following cycle SEAL, alarme=0.
REQ-031 pos_ve dropped at the 2nd SEAL cycle -> IDLE, estoque unchanged, ve_done never asserted.
REQ-032 7 refill pulses from 0 -> estoque saturates at 99 (not 105, no wrap).
REQ-033 Refill pulse on the last SEAL cycle with estoque=99 -> estoque=99; with estoque=10 -> estoque=24.
REQ-034 reset=0 asserted asynchronously between clock edges during SEAL -> outputs clear before the next edge, state=IDLE.

Source files
------------

// File: rtl/vedacao_ctrl.sv
// ---------------------------------------------------------------------------
// vedacao_ctrl -- bottle capping (sealing) station controller.
//
// Holds the capper actuator on for SEAL_CYCLES cycles per bottle in position,
// keeps a saturating stock count of caps, raises an alarm when a bottle is
// waiting and no caps are left, and guarantees one seal per bottle.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous reset, active low
//   pos_ve      in   bottle held in sealing position (level)
//   add_rolhas  in   refill request, each high cycle adds REFILL caps
//   selador     out  capper actuator drive
//   ve_done     out  one-cycle pulse, current bottle sealed
//   alarme      out  stock empty while a bottle waits
//   estoque     out  current cap stock, 0..MAX_STOCK
//   busy        out  controller not idle
//
// All outputs decode registered state only.
// ---------------------------------------------------------------------------
module vedacao_ctrl #(
  parameter int SEAL_CYCLES = 4,   // 1..15
  parameter int REFILL      = 15,
  parameter int MAX_STOCK   = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pos_ve,
  input  logic       add_rolhas,
  output logic       selador,
  output logic       ve_done,
  output logic       alarme,
  output logic [6:0] estoque,
  output logic       busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SEAL    = 3'd1;
  localparam logic [2:0] S_DONE    = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_EMPTY   = 3'd4;

  localparam logic [3:0] TLOAD    = 4'(SEAL_CYCLES - 1);
  localparam logic [8:0] REFILL_W = 9'(REFILL);
  localparam logic [8:0] MAX_W    = 9'(MAX_STOCK);

  logic [2:0] state_q, state_d;
  logic [3:0] timer_q, timer_d;
  logic [6:0] stock_q, stock_d;
  logic       dec;
  logic [8:0] sum_w;
  logic       has_stock;

  assign has_stock = (stock_q != 7'd0);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dec     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pos_ve && has_stock) begin
          state_d = S_SEAL;
          timer_d = TLOAD;
        end else if (pos_ve) begin
          state_d = S_EMPTY;
        end
      end
      S_SEAL: begin
        // Line stop wins over completion: an aborted bottle consumes no cap.
        if (!pos_ve) begin
          state_d = S_IDLE;
        end else if (timer_q == 4'd0) begin
          state_d = S_DONE;
          dec     = 1'b1;
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      S_DONE:    state_d = S_RELEASE;
      // Bottle must leave position before the next one can be sealed.
      S_RELEASE: if (!pos_ve) state_d = S_IDLE;
      S_EMPTY: begin
        if (!pos_ve) begin
          state_d = S_IDLE;
        end else if (has_stock) begin
          state_d = S_SEAL;
          timer_d = TLOAD;
        end
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // 9-bit sum so refill plus stock never wraps before saturation. dec only
  // fires in SEAL, which is only entered with stock > 0, so no underflow.
  always_comb begin
    sum_w   = {2'b00, stock_q} + (add_rolhas ? REFILL_W : 9'd0) - {8'd0, dec};
    stock_d = (sum_w > MAX_W) ? MAX_W[6:0] : sum_w[6:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      timer_q <= 4'd0;
      stock_q <= 7'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      stock_q <= stock_d;
    end
  end

  assign selador = (state_q == S_SEAL);
  assign ve_done = (state_q == S_DONE);
  assign alarme  = (state_q == S_EMPTY);
  assign busy    = (state_q != S_IDLE);
  assign estoque = stock_q;

endmodule

// File: tb/tb_vedacao_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vedacao_ctrl -- scripted scenarios with a queue of expected output
// vectors {selador, ve_done, alarme, busy, estoque}; each step drives inputs,
// pushes its expectation, clocks once and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_vedacao_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pos_ve = 1'b0;
  logic       add_rolhas = 1'b0;
  logic       selador, ve_done, alarme, busy;
  logic [6:0] estoque;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [10:0] exp;
  } exp_t;
  exp_t sb_q[$];

  vedacao_ctrl #(.SEAL_CYCLES(4), .REFILL(15), .MAX_STOCK(99)) dut (
    .clk        (clk),
    .reset      (reset),
    .pos_ve     (pos_ve),
    .add_rolhas (add_rolhas),
    .selador    (selador),
    .ve_done    (ve_done),
    .alarme     (alarme),
    .estoque    (estoque),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] obs();
    return {selador, ve_done, alarme, busy, estoque};
  endfunction

  task automatic chk(input string tag, input logic [10:0] act, input logic [10:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got sel/done/alm/busy/stk=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
               tag, act[10], act[9], act[8], act[7], act[6:0],
               exp[10], exp[9], exp[8], exp[7], exp[6:0]);
    end
  endtask

  // Called at a falling edge: drive, expect, clock, compare.
  task automatic step(input string tag, input logic p, input logic a,
                      input logic s, input logic d, input logic al,
                      input logic b, input int stk);
    exp_t e;
    pos_ve     = p;
    add_rolhas = a;
    e.tag = tag;
    e.exp = {s, d, al, b, 7'(stk)};
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    chk(e.tag, obs(), e.exp);
  endtask

  // One full bottle from IDLE: 4 SEAL cycles, DONE, RELEASE, IDLE.
  task automatic seal_one(input int s, input logic add_last, input int s_after);
    for (int i = 0; i < 4; i++) step("seal_on", 1, 0, 1, 0, 0, 1, s);
    step("seal_done", 1, add_last, 0, 1, 0, 1, s_after);
    step("release", 0, 0, 0, 0, 0, 1, s_after);
    step("idle", 0, 0, 0, 0, 0, 0, s_after);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    pos_ve = 1'b0;
    add_rolhas = 1'b0;
    @(negedge clk);
    chk("reset_state", obs(), 11'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("reset_async", obs(), 11'd0);
    do_reset();

    // One refill, bottle held: single seal, no reseal until pos_ve toggles
    step("refill1", 0, 1, 0, 0, 0, 0, 15);
    step("seal_c1", 1, 0, 1, 0, 0, 1, 15);
    step("seal_c2", 1, 0, 1, 0, 0, 1, 15);
    step("seal_c3", 1, 0, 1, 0, 0, 1, 15);
    step("seal_c4", 1, 0, 1, 0, 0, 1, 15);
    step("done", 1, 0, 0, 1, 0, 1, 14);
    for (int i = 0; i < 4; i++) step("hold_release", 1, 0, 0, 0, 0, 1, 14);
    step("leave", 0, 0, 0, 0, 0, 0, 14);

    // Line stop at the 2nd SEAL cycle
    step("abort_c1", 1, 0, 1, 0, 0, 1, 14);
    step("abort_c2", 1, 0, 1, 0, 0, 1, 14);
    step("abort_idle", 0, 0, 0, 0, 0, 0, 14);
    step("abort_nodone", 0, 0, 0, 0, 0, 0, 14);

    // Asynchronous reset between edges during SEAL
    step("pre_rst_seal", 1, 0, 1, 0, 0, 1, 14);
    #2 reset = 1'b0;
    #1 chk("rst_mid_seal", obs(), 11'd0);
    @(negedge clk);
    chk("rst_held", obs(), 11'd0);
    reset = 1'b1;

    // Empty stock with bottle waiting, then refill
    step("empty_alarm", 1, 0, 0, 0, 1, 1, 0);
    step("empty_stay", 1, 0, 0, 0, 1, 1, 0);
    step("empty_refill", 1, 1, 0, 0, 1, 1, 15);
    step("empty_to_seal", 1, 0, 1, 0, 0, 1, 15);
    step("seal_abort", 0, 0, 0, 0, 0, 0, 15);
    step("empty_no_pos", 0, 0, 0, 0, 0, 0, 15);

    // Empty exit by bottle removal
    do_reset();
    step("empty2", 1, 0, 0, 0, 1, 1, 0);
    step("empty_leave", 0, 0, 0, 0, 0, 0, 0);

    // Saturation: 8 refill pulses from 0
    step("sat1", 0, 1, 0, 0, 0, 0, 15);
    step("sat2", 0, 1, 0, 0, 0, 0, 30);
    step("sat3", 0, 1, 0, 0, 0, 0, 45);
    step("sat4", 0, 1, 0, 0, 0, 0, 60);
    step("sat5", 0, 1, 0, 0, 0, 0, 75);
    step("sat6", 0, 1, 0, 0, 0, 0, 90);
    step("sat7", 0, 1, 0, 0, 0, 0, 99);
    step("sat8", 0, 1, 0, 0, 0, 0, 99);

    // Refill on last SEAL cycle at full stock
    seal_one(99, 1'b1, 99);
    // Plain seal at full stock
    seal_one(99, 1'b0, 98);

    // Bring stock to 10 then refill on the last SEAL cycle -> 24
    do_reset();
    step("refill_to15", 0, 1, 0, 0, 0, 0, 15);
    for (int k = 0; k < 5; k++) seal_one(15 - k, 1'b0, 14 - k);
    seal_one(10, 1'b1, 24);

    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
